// File: rtl/tri_st_rot_seq_if.sv
// Handshake bundle between the per-thread rotate/logical requesters, the
// rotate decoder and writeback on one side, and the issue sequencer on the other.
interface tri_st_rot_seq_if #(
  parameter int THREADS = 2
);
  logic [THREADS-1:0]    rf1_req_vld;
  logic [32*THREADS-1:0] rf1_req_instr;
  logic [THREADS-1:0]    rf1_gnt;
  logic [THREADS-1:0]    flush;
  logic                  ex1_sra;
  logic                  ex3_stall;
  logic                  ex1_vld;
  logic                  ex2_vld;
  logic                  ex3_vld;
  logic [THREADS-1:0]    ex1_tid;
  logic [THREADS-1:0]    ex2_tid;
  logic [THREADS-1:0]    ex3_tid;
  logic [31:0]           ex1_instr;
  logic                  ex2_sra_pass2;
  logic [THREADS-1:0]    ex3_done;
  logic [THREADS-1:0]    busy;

  // Environment side: requesters, decoder return, flush and writeback.
  modport master (
    output rf1_req_vld, rf1_req_instr, flush, ex1_sra, ex3_stall,
    input  rf1_gnt, ex1_vld, ex2_vld, ex3_vld, ex1_tid, ex2_tid, ex3_tid,
    input  ex1_instr, ex2_sra_pass2, ex3_done, busy
  );

  // Sequencer side.
  modport slave (
    input  rf1_req_vld, rf1_req_instr, flush, ex1_sra, ex3_stall,
    output rf1_gnt, ex1_vld, ex2_vld, ex3_vld, ex1_tid, ex2_tid, ex3_tid,
    output ex1_instr, ex2_sra_pass2, ex3_done, busy
  );
endinterface

// File: rtl/tri_st_rot_seq.sv
// Issue sequencer for the shared rotate/logical datapath: round-robin grant of
// per-thread requests onto an ex1/ex2/ex3 pipe, an extra ex2 cycle for
// sra-class ops, per-thread flush and writeback backpressure.
module tri_st_rot_seq #(
  parameter int THREADS = 2
) (
  input logic             clk,
  input logic             rst,
  tri_st_rot_seq_if.slave bus
);
  localparam int PW = (THREADS > 1) ? $clog2(THREADS) : 1;
  localparam logic [PW-1:0] PTR_RESET = PW'(THREADS - 1);

  typedef enum logic [1:0] {
    SRA_IDLE,
    SRA_P1,
    SRA_P2
  } sra_state_t;

  logic               ex1_vld_q, ex2_vld_q, ex3_vld_q;
  logic [THREADS-1:0] ex1_tid_q, ex2_tid_q, ex3_tid_q;
  logic [31:0]        ex1_instr_q;
  logic               ex2_sra_q;
  sra_state_t         ex2_state_q;
  logic [PW-1:0]      rr_ptr_q;

  logic               ex1_vld_d, ex2_vld_d, ex3_vld_d;
  logic [THREADS-1:0] ex1_tid_d, ex2_tid_d, ex3_tid_d;
  logic [31:0]        ex1_instr_d;
  logic               ex2_sra_d;
  sra_state_t         ex2_state_d;
  logic [PW-1:0]      rr_ptr_d;

  logic kill1, kill2, kill3;
  logic adv3, ex2_move, ex2_free, ex1_move, ex1_free;

  logic [THREADS-1:0] eligible;
  logic [THREADS-1:0] gnt;
  logic [PW-1:0]      gnt_idx;
  logic [PW-1:0]      cand;
  logic               gnt_any;
  logic [31:0]        gnt_instr;

  // Flush kills and the back-to-front advance chain; a killed stage is treated
  // as empty so the stage behind it can refill on the same edge.
  always_comb begin
    kill1    = ex1_vld_q & (|(ex1_tid_q & bus.flush));
    kill2    = ex2_vld_q & (|(ex2_tid_q & bus.flush));
    kill3    = ex3_vld_q & (|(ex3_tid_q & bus.flush));
    adv3     = ~ex3_vld_q | ~bus.ex3_stall | kill3;
    ex2_move = ex2_vld_q & ~kill2 & (~ex2_sra_q | (ex2_state_q == SRA_P2)) & adv3;
    ex2_free = ~ex2_vld_q | kill2 | ex2_move;
    ex1_move = ex1_vld_q & ~kill1 & ex2_free;
    ex1_free = ~ex1_vld_q | kill1 | ex1_move;
  end

  // Round-robin arbiter: first eligible thread after the pointer, only when ex1 can accept.
  always_comb begin
    eligible  = bus.rf1_req_vld & ~bus.flush;
    gnt       = '0;
    gnt_idx   = '0;
    cand      = '0;
    gnt_any   = 1'b0;
    gnt_instr = '0;
    if (ex1_free) begin
      for (int i = 1; i <= THREADS; i++) begin
        cand = PW'((int'(rr_ptr_q) + i) % THREADS);
        if (!gnt_any && eligible[cand]) begin
          gnt_any      = 1'b1;
          gnt_idx      = cand;
          gnt[cand]    = 1'b1;
        end
      end
    end
    for (int t = 0; t < THREADS; t++) begin
      if (gnt[t]) gnt_instr = bus.rf1_req_instr[32*t +: 32];
    end
  end

  // Next-state for every stage and the ex2 sra hold FSM; defaults hold state.
  always_comb begin
    ex1_vld_d   = ex1_vld_q;
    ex1_tid_d   = ex1_tid_q;
    ex1_instr_d = ex1_instr_q;
    ex2_vld_d   = ex2_vld_q;
    ex2_tid_d   = ex2_tid_q;
    ex2_sra_d   = ex2_sra_q;
    ex2_state_d = ex2_state_q;
    ex3_vld_d   = ex3_vld_q;
    ex3_tid_d   = ex3_tid_q;
    rr_ptr_d    = rr_ptr_q;

    if (ex2_move) begin
      ex3_vld_d = 1'b1;
      ex3_tid_d = ex2_tid_q;
    end else if (adv3) begin
      ex3_vld_d = 1'b0;
      ex3_tid_d = '0;
    end

    if (ex1_move) begin
      ex2_vld_d   = 1'b1;
      ex2_tid_d   = ex1_tid_q;
      ex2_sra_d   = bus.ex1_sra;
      ex2_state_d = SRA_P1;
    end else if (kill2 || ex2_move) begin
      ex2_vld_d   = 1'b0;
      ex2_tid_d   = '0;
      ex2_sra_d   = 1'b0;
      ex2_state_d = SRA_IDLE;
    end else if (ex2_state_q == SRA_P1 && ex2_sra_q) begin
      ex2_state_d = SRA_P2;
    end

    if (gnt_any) begin
      ex1_vld_d   = 1'b1;
      ex1_tid_d   = gnt;
      ex1_instr_d = gnt_instr;
      rr_ptr_d    = gnt_idx;
    end else if (ex1_move || kill1) begin
      ex1_vld_d   = 1'b0;
      ex1_tid_d   = '0;
      ex1_instr_d = '0;
    end
  end

  // Stage and pointer registers; reset empties the pipe and aims the pointer so thread 0 wins first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex1_vld_q   <= 1'b0;
      ex1_tid_q   <= '0;
      ex1_instr_q <= '0;
      ex2_vld_q   <= 1'b0;
      ex2_tid_q   <= '0;
      ex2_sra_q   <= 1'b0;
      ex2_state_q <= SRA_IDLE;
      ex3_vld_q   <= 1'b0;
      ex3_tid_q   <= '0;
      rr_ptr_q    <= PTR_RESET;
    end else begin
      ex1_vld_q   <= ex1_vld_d;
      ex1_tid_q   <= ex1_tid_d;
      ex1_instr_q <= ex1_instr_d;
      ex2_vld_q   <= ex2_vld_d;
      ex2_tid_q   <= ex2_tid_d;
      ex2_sra_q   <= ex2_sra_d;
      ex2_state_q <= ex2_state_d;
      ex3_vld_q   <= ex3_vld_d;
      ex3_tid_q   <= ex3_tid_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign bus.rf1_gnt       = rst ? '0 : gnt;
  assign bus.ex1_vld       = ex1_vld_q;
  assign bus.ex2_vld       = ex2_vld_q;
  assign bus.ex3_vld       = ex3_vld_q;
  assign bus.ex1_tid       = ex1_tid_q;
  assign bus.ex2_tid       = ex2_tid_q;
  assign bus.ex3_tid       = ex3_tid_q;
  assign bus.ex1_instr     = ex1_instr_q;
  assign bus.ex2_sra_pass2 = (ex2_state_q == SRA_P2);
  assign bus.ex3_done      = (ex3_vld_q & ~bus.ex3_stall & ~kill3) ? ex3_tid_q : '0;
  assign bus.busy          = (ex1_tid_q & {THREADS{ex1_vld_q}})
                           | (ex2_tid_q & {THREADS{ex2_vld_q}})
                           | (ex3_tid_q & {THREADS{ex3_vld_q}});
endmodule
